// File: rtl/corr_peak_select.sv
// Picks the highest of eleven captured correlation words, sweeping one per cycle.
// Result valid 11 cycles after the capturing wen; a wen during a scan is dropped and flagged.
module corr_peak_select #(
    parameter int sh_reg_w = 8,
    parameter int n_disp   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [2*sh_reg_w-1:0] corr_in_0,
    input  logic [2*sh_reg_w-1:0] corr_in_1,
    input  logic [2*sh_reg_w-1:0] corr_in_2,
    input  logic [2*sh_reg_w-1:0] corr_in_3,
    input  logic [2*sh_reg_w-1:0] corr_in_4,
    input  logic [2*sh_reg_w-1:0] corr_in_5,
    input  logic [2*sh_reg_w-1:0] corr_in_6,
    input  logic [2*sh_reg_w-1:0] corr_in_7,
    input  logic [2*sh_reg_w-1:0] corr_in_8,
    input  logic [2*sh_reg_w-1:0] corr_in_9,
    input  logic [2*sh_reg_w-1:0] corr_in_10,
    input  logic [2*sh_reg_w-1:0] thresh,
    output logic [3:0]            disp_out,
    output logic [2*sh_reg_w-1:0] corr_max,
    output logic                  conf,
    output logic                  valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam int          cw   = 2*sh_reg_w;
    localparam logic [3:0]  last_idx = 4'(n_disp-1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state;
    state_t          state_nx;
    logic            capture;
    logic            last;
    logic [cw-1:0]   corr_arr [n_disp];
    logic [cw-1:0]   bank [n_disp];
    logic [cw-1:0]   thresh_q;
    logic [3:0]      cnt;
    logic [3:0]      best_idx;
    logic [cw-1:0]   best_val;
    logic [cw-1:0]   cand;
    logic [3:0]      nb_idx;
    logic [cw-1:0]   nb_val;

    assign corr_arr[0]  = corr_in_0;
    assign corr_arr[1]  = corr_in_1;
    assign corr_arr[2]  = corr_in_2;
    assign corr_arr[3]  = corr_in_3;
    assign corr_arr[4]  = corr_in_4;
    assign corr_arr[5]  = corr_in_5;
    assign corr_arr[6]  = corr_in_6;
    assign corr_arr[7]  = corr_in_7;
    assign corr_arr[8]  = corr_in_8;
    assign corr_arr[9]  = corr_in_9;
    assign corr_arr[10] = corr_in_10;

    assign busy = (state == SCAN);
    assign last = (cnt == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE: if (wen) begin
                capture  = 1'b1;
                state_nx = SCAN;
            end
            SCAN: if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        cand   = bank[cnt];
        nb_val = best_val;
        nb_idx = best_idx;
        if (cand > best_val) begin
            nb_val = cand;
            nb_idx = cnt;
        end
    end

    // Bank contents need no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < n_disp; i++) bank[i] <= corr_arr[i];
            thresh_q <= thresh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
            disp_out <= '0;
            corr_max <= '0;
            conf     <= 1'b0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (wen && state == SCAN) overrun <= 1'b1;
            if (capture) begin
                best_val <= corr_arr[0];
                best_idx <= 4'd0;
                cnt      <= 4'd1;
            end else if (state == SCAN) begin
                best_val <= nb_val;
                best_idx <= nb_idx;
                cnt      <= last ? 4'd0 : cnt + 4'd1;
                if (last) begin
                    disp_out <= nb_idx;
                    corr_max <= nb_val;
                    conf     <= (nb_val >= thresh_q);
                    valid    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_corr_peak_select.sv
// Bench for corr_peak_select: vector table run back-to-back plus latency, overrun and reset sequences.
module tb_corr_peak_select;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [15:0] corr [11];
    logic [15:0] thresh;
    logic [3:0]  disp_out;
    logic [15:0] corr_max;
    logic        conf, valid, busy, overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [10:0][15:0] v;
        logic [15:0]       thr;
        logic [3:0]        d;
        logic [15:0]       m;
        logic              c;
    } vec_t;

    typedef struct packed {
        logic [3:0]  d;
        logic [15:0] m;
        logic        c;
        logic [31:0] cyc;
    } exp_t;

    vec_t tbl [7];
    exp_t sb [$];

    corr_peak_select dut (
        .clk(clk), .rst(rst), .wen(wen),
        .corr_in_0(corr[0]), .corr_in_1(corr[1]), .corr_in_2(corr[2]),
        .corr_in_3(corr[3]), .corr_in_4(corr[4]), .corr_in_5(corr[5]),
        .corr_in_6(corr[6]), .corr_in_7(corr[7]), .corr_in_8(corr[8]),
        .corr_in_9(corr[9]), .corr_in_10(corr[10]),
        .thresh(thresh), .disp_out(disp_out), .corr_max(corr_max),
        .conf(conf), .valid(valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Valid is set at the 10th edge after the capture edge and seen at the next negedge.
    task automatic send(input logic [10:0][15:0] v, input logic [15:0] thr, input bit push,
                        input logic [3:0] d, input logic [15:0] m, input logic c);
        exp_t e;
        for (int k = 0; k < 11; k++) corr[k] = v[k];
        thresh = thr;
        wen    = 1'b1;
        if (push) begin
            e.d = d; e.m = m; e.c = c; e.cyc = 32'(cyc + 11);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("disp_out", 32'(disp_out), 32'(e.d));
                check("corr_max", 32'(corr_max), 32'(e.m));
                check("conf", 32'(conf), 32'(e.c));
                check("valid_cycle", 32'(cyc), e.cyc);
            end
        end
    end

    initial begin
        logic [10:0][15:0] v;
        rst = 1'b1; wen = 1'b0; thresh = '0;
        for (int k = 0; k < 11; k++) corr[k] = '0;

        for (int k = 0; k < 11; k++) tbl[0].v[k] = 16'(100*k);
        tbl[0].thr = 16'd500; tbl[0].d = 4'd10; tbl[0].m = 16'd1000; tbl[0].c = 1'b1;
        for (int k = 0; k < 11; k++) tbl[1].v[k] = 16'h0040;
        tbl[1].v[3] = 16'h1234; tbl[1].v[7] = 16'h1234;
        tbl[1].thr = 16'hFFFF; tbl[1].d = 4'd3; tbl[1].m = 16'h1234; tbl[1].c = 1'b0;
        for (int k = 0; k < 11; k++) tbl[2].v[k] = 16'hFFFE;
        tbl[2].v[0] = 16'hFFFF;
        tbl[2].thr = 16'hFFFF; tbl[2].d = 4'd0; tbl[2].m = 16'hFFFF; tbl[2].c = 1'b1;
        for (int k = 0; k < 11; k++) tbl[3].v[k] = 16'h0000;
        tbl[3].thr = 16'h0000; tbl[3].d = 4'd0; tbl[3].m = 16'h0000; tbl[3].c = 1'b1;
        for (int k = 0; k < 11; k++) tbl[4].v[k] = 16'h0100;
        tbl[4].v[5] = 16'h0500;
        tbl[4].thr = 16'h0500; tbl[4].d = 4'd5; tbl[4].m = 16'h0500; tbl[4].c = 1'b1;
        tbl[5] = tbl[4];
        tbl[5].thr = 16'h0501; tbl[5].c = 1'b0;
        for (int k = 0; k < 11; k++) tbl[6].v[k] = 16'h2000;
        tbl[6].v[0] = 16'h1FFF;
        tbl[6].thr = 16'h2000; tbl[6].d = 4'd1; tbl[6].m = 16'h2000; tbl[6].c = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_disp_out", 32'(disp_out), 0);
        check("rst_corr_max", 32'(corr_max), 0);
        check("rst_conf", 32'(conf), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Ramp frame: busy across the ten scan cycles, low in the valid cycle.
        @(posedge clk) #1;
        send(tbl[0].v, tbl[0].thr, 1'b1, tbl[0].d, tbl[0].m, tbl[0].c);
        @(posedge clk) #1 wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ramp_busy_scan", 32'(busy), 1);
            @(posedge clk);
        end
        @(negedge clk);
        check("ramp_valid_at_11", 32'(valid), 1);
        check("ramp_busy_done", 32'(busy), 0);
        drain();

        // Table frames back-to-back, next wen in each valid cycle; inputs scrambled after capture.
        @(posedge clk) #1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].v, tbl[i].thr, 1'b1, tbl[i].d, tbl[i].m, tbl[i].c);
            @(posedge clk) #1;
            wen = 1'b0;
            for (int k = 0; k < 11; k++) corr[k] = 16'hFFFF;
            thresh = 16'h0000;
            repeat (10) @(posedge clk);
            #1;
        end
        drain();
        check("overrun_clear_before", 32'(overrun), 0);

        // Overrun: second wen at cycle 4 is dropped, then a wen in the valid cycle is taken.
        @(posedge clk) #1;
        for (int k = 0; k < 11; k++) v[k] = 16'h0100;
        v[5] = 16'h0700;
        send(v, 16'h0000, 1'b1, 4'd5, 16'h0700, 1'b1);
        @(posedge clk) #1 wen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v[9] = 16'h7000;
        send(v, 16'h0000, 1'b0, 4'd0, 16'h0, 1'b0);
        @(posedge clk) #1 wen = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(overrun), 1);
        begin
            int n;
            n = 0;
            while (valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("overrun_valid_seen", 32'(valid), 1);
        end
        check("overrun_sticky", 32'(overrun), 1);
        for (int k = 0; k < 11; k++) v[k] = 16'h0030;
        v[8] = 16'h0900;
        send(v, 16'h0900, 1'b1, 4'd8, 16'h0900, 1'b1);
        @(posedge clk) #1 wen = 1'b0;
        drain();
        check("overrun_still_set", 32'(overrun), 1);

        // Reset at cycle 6 of a scan aborts it; wen held during reset is ignored.
        @(posedge clk) #1;
        send(v, 16'h0000, 1'b0, 4'd0, 16'h0, 1'b0);
        @(posedge clk) #1 wen = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_disp_out", 32'(disp_out), 0);
        check("abort_corr_max", 32'(corr_max), 0);
        check("abort_conf", 32'(conf), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_overrun", 32'(overrun), 0);
        wen = 1'b1;
        @(posedge clk) #1;
        wen = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("wen_in_rst_ignored", 32'(busy), 0);
        repeat (12) @(negedge clk);
        check("abort_no_valid_disp", 32'(disp_out), 0);
        @(posedge clk) #1;
        for (int k = 0; k < 11; k++) v[k] = 16'h0400;
        v[2] = 16'h0800;
        send(v, 16'h0800, 1'b1, 4'd2, 16'h0800, 1'b1);
        @(posedge clk) #1 wen = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
